// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown phase timer.
//   state_t       : FSM state encoding (IDLE / RUN / PAUSE)
//   NBITS_DEFAULT : default width of the count, start and terminal values
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam int NBITS_DEFAULT = 32;

endpackage

// File: rtl/countdown_timer_decrementer_st.sv
// Decrement-and-compare datapath for the countdown timer.
// Ports:
//   a  in  NBITS  value to decrement
//   b  in  NBITS  compare target
//   r  out NBITS  a - 1 (unsigned)
//   eq out 1      high when (a - 1) == b
module decrementer_st #(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    output logic [NBITS-1:0] r,
    output logic             eq
);

    assign r  = a - NBITS'(1);
    assign eq = (r == b);

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counting phase timer. Counts q from a latched start value
// down to a latched terminal value, one step per ce pulse, then pulses tick
// and either reloads (periodic) or stops (one-shot).
// Ports:
//   clk         in   1      rising-edge clock
//   rst_n       in   1      synchronous active-low reset
//   ce          in   1      count enable, one decrement per ce cycle
//   load        in   1      latch cnt_ini/cnt_end/autoreload and start
//   autoreload  in   1      sampled at load: 1 periodic, 0 one-shot
//   pause       in   1      level, freezes counting while high
//   cnt_ini     in   NBITS  start value
//   cnt_end     in   NBITS  terminal value
//   q           out  NBITS  current count
//   tick        out  1      1-cycle pulse when the terminal value is reached
//   busy        out  1      high in RUN or PAUSE
//   err         out  1      1-cycle pulse when a load is rejected
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | stopped, q holds last value, ce/pause ignored
// S_RUN   | decrementing on each ce
// S_PAUSE | frozen by pause; ce ignored until release
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int NBITS = NBITS_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             load,
    input  logic             autoreload,
    input  logic             pause,
    input  logic [NBITS-1:0] cnt_ini,
    input  logic [NBITS-1:0] cnt_end,
    output logic [NBITS-1:0] q,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    state_t             state_q, state_n;
    logic [NBITS-1:0]   q_r, q_n;
    logic [NBITS-1:0]   ini_r, ini_n;
    logic [NBITS-1:0]   end_r, end_n;
    logic               ar_r, ar_n;
    logic               tick_r, tick_n;
    logic               err_r, err_n;
    logic [NBITS-1:0]   dec_q;
    logic               dec_hit;
    logic               load_ok;

    decrementer_st #(.NBITS(NBITS)) u_dec (
        .a  (q_r),
        .b  (end_r),
        .r  (dec_q),
        .eq (dec_hit)
    );

    // A zero-length or inverted period would make the decrement wrap.
    assign load_ok = (cnt_ini > cnt_end);

    always_comb begin
        state_n = state_q;
        q_n     = q_r;
        ini_n   = ini_r;
        end_n   = end_r;
        ar_n    = ar_r;
        tick_n  = 1'b0;
        err_n   = 1'b0;

        if (load) begin
            if (load_ok) begin
                q_n     = cnt_ini;
                ini_n   = cnt_ini;
                end_n   = cnt_end;
                ar_n    = autoreload;
                state_n = pause ? S_PAUSE : S_RUN;
            end else begin
                err_n = 1'b1;
            end
        end else begin
            unique case (state_q)
                S_RUN: begin
                    if (pause) begin
                        state_n = S_PAUSE;
                    end else if (ce) begin
                        if (dec_hit) begin
                            tick_n = 1'b1;
                            if (ar_r) begin
                                q_n = ini_r;
                            end else begin
                                q_n     = end_r;
                                state_n = S_IDLE;
                            end
                        end else begin
                            q_n = dec_q;
                        end
                    end
                end
                S_PAUSE: begin
                    // The ce arriving in the release cycle is deliberately dropped.
                    if (!pause) begin
                        state_n = S_RUN;
                    end
                end
                S_IDLE: begin
                    state_n = S_IDLE;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            q_r     <= '0;
            ini_r   <= '0;
            end_r   <= '0;
            ar_r    <= 1'b0;
            tick_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_q <= state_n;
            q_r     <= q_n;
            ini_r   <= ini_n;
            end_r   <= end_n;
            ar_r    <= ar_n;
            tick_r  <= tick_n;
            err_r   <= err_n;
        end
    end

    assign q    = q_r;
    assign tick = tick_r;
    assign err  = err_r;
    assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

    localparam int NBITS = 32;

    typedef struct {
        logic             rst_n;
        logic             load;
        logic             ce;
        logic             pause;
        logic             ar;
        logic [NBITS-1:0] ini;
        logic [NBITS-1:0] fin;
        logic [NBITS-1:0] eq;
        logic             et;
        logic             eb;
        logic             ee;
    } vec_t;

    typedef struct {
        logic [NBITS-1:0] q;
        logic             tick;
        logic             busy;
        logic             err;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             ce;
    logic             load;
    logic             autoreload;
    logic             pause;
    logic [NBITS-1:0] cnt_ini;
    logic [NBITS-1:0] cnt_end;
    logic [NBITS-1:0] q;
    logic             tick;
    logic             busy;
    logic             err;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t vecs[$];
    exp_t sb[$];

    countdown_timer #(.NBITS(NBITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ce         (ce),
        .load       (load),
        .autoreload (autoreload),
        .pause      (pause),
        .cnt_ini    (cnt_ini),
        .cnt_end    (cnt_end),
        .q          (q),
        .tick       (tick),
        .busy       (busy),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic ld, input logic c, input logic p,
                                input logic a, input int ini, input int fin,
                                input int eq, input logic et, input logic eb, input logic ee);
        vec_t v;
        v.rst_n = r;  v.load = ld; v.ce = c; v.pause = p; v.ar = a;
        v.ini = NBITS'(ini); v.fin = NBITS'(fin);
        v.eq = NBITS'(eq); v.et = et; v.eb = eb; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected outputs, and compare
    // them one edge later.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        rst_n      = v.rst_n;
        load       = v.load;
        ce         = v.ce;
        pause      = v.pause;
        autoreload = v.ar;
        cnt_ini    = v.ini;
        cnt_end    = v.fin;
        e.q = v.eq; e.tick = v.et; e.busy = v.eb; e.err = v.ee;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: queue empty, expected 1 entry");
        end else begin
            got = sb.pop_front();
            chk("q",    q,           got.q);
            chk("tick", NBITS'(tick), NBITS'(got.tick));
            chk("busy", NBITS'(busy), NBITS'(got.busy));
            chk("err",  NBITS'(err),  NBITS'(got.err));
        end
    endtask

    initial begin
        int k;
        rst_n = 1'b0; load = 1'b0; ce = 1'b0; pause = 1'b0;
        autoreload = 1'b0; cnt_ini = '0; cnt_end = '0;

        //               rst ld ce p  ar ini fin   q  t  b  e
        // reset, then ce in IDLE has no effect
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0));
        // one-shot 5 -> 0, ce every cycle (ce in load cycle dropped)
        vecs.push_back(mk(1, 1, 1, 0, 0, 5, 0,    5, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    4, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    1, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0,    0, 0, 0, 0));
        // rejected loads: ini == end, ini < end
        vecs.push_back(mk(1, 1, 0, 0, 1, 2, 2,    0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 1, 4,    0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0));
        // rejected load while running keeps q and state, drops ce
        vecs.push_back(mk(1, 1, 0, 0, 0, 10, 0,  10, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    9, 0, 1, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 3, 3,    9, 0, 1, 1));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    8, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    7, 0, 1, 0));
        // pause at q=7 for 5 cycles with ce toggling
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0,    7, 0, 1, 0));
        // release: ce in release cycle ignored, next ce decrements
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    6, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    5, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    4, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    2, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    1, 0, 1, 0));
        // restart at q=1 with coincident ce: no tick, restart from 9
        vecs.push_back(mk(1, 1, 1, 0, 0, 9, 0,    9, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    8, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    6, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    5, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    4, 0, 1, 0));
        // reset mid-count, then ce has no effect
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    0, 0, 0, 0));
        // load with pause high enters PAUSE
        vecs.push_back(mk(1, 1, 1, 1, 0, 4, 0,    4, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 0,    4, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    4, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    3, 0, 1, 0));
        // one-shot with non-zero terminal value stops at 6
        vecs.push_back(mk(1, 1, 0, 0, 0, 8, 6,    8, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    7, 0, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    6, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,    6, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Periodic mode: ini=3 end=1, ce every 2nd cycle. autoreload input
        // is dropped after load to show it is only sampled at load.
        step(mk(1, 1, 0, 0, 1, 3, 1,    3, 0, 1, 0));
        k = 0;
        for (int i = 0; i < 16; i++) begin
            logic c;
            c = (i % 2 == 0);
            if (c) k++;
            if (c && (k % 2 == 0))
                step(mk(1, 0, c, 0, 0, 0, 0, 3, 1, 1, 0));
            else if (c)
                step(mk(1, 0, c, 0, 0, 0, 0, 2, 0, 1, 0));
            else
                step(mk(1, 0, c, 0, 0, 0, 0, (k % 2 == 0) ? 3 : 2, 0, 1, 0));
        end

        // Periodic with ce every cycle: tick every 2 cycles, no idle gap.
        step(mk(1, 1, 1, 0, 1, 2, 0,    2, 0, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 0,    1, 0, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 0,    2, 1, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 0,    1, 0, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 0,    2, 1, 1, 0));
        // Large values near the top of the range.
        step(mk(1, 1, 0, 0, 0, -1, -3,  -1, 0, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 0,    -2, 0, 1, 0));
        step(mk(1, 0, 1, 0, 0, 0, 0,    -3, 1, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
